// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default frame geometry.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Byte output channel of the UART receiver: valid/ready data plus error/status pulses.
interface uart_rx_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 overrun_err;
    logic                 busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun_err, busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun_err, busy,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous pad input; reset value selectable.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// UART receiver (8N1 default): oversampled start/data/stop decode feeding a
// one-entry valid/ready holding register with frame and overrun error pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic        tick_16x,
    input  logic        rx_in,
    uart_rx_if.master   bus
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_state_e          r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun_err;
    logic                 r_busy;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .i_clk (clk_in),
        .i_rst (rst),
        .i_d   (rx_in),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_bit         <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
            // Consumer handshake; a deliver below in the same cycle overrides the clear.
            if (r_valid && bus.rx_ready)
                r_valid <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (tick_16x) begin
                        if (r_cnt == CNT_HALF) begin
                            if (!w_rx_s) begin
                                r_state <= DATA;
                                r_cnt   <= '0;
                                r_bit   <= '0;
                            end else begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                DATA: begin
                    if (tick_16x) begin
                        if (r_cnt == CNT_LAST) begin
                            // LSB arrives first, so shift in from the top.
                            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                            r_cnt   <= '0;
                            r_bit   <= r_bit + 1'b1;
                            if (r_bit == BIT_LAST)
                                r_state <= STOP;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (tick_16x) begin
                        if (r_cnt == CNT_LAST) begin
                            r_cnt <= '0;
                            if (w_rx_s) begin
                                r_state <= IDLE;
                                r_busy  <= 1'b0;
                                if (!r_valid || bus.rx_ready) begin
                                    r_data  <= r_shift;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_overrun_err <= 1'b1;
                                end
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= BREAK;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

                BREAK: begin
                    // Hold off until the line recovers so a stuck-low line is not read as 0x00 frames.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data     = r_data;
    assign bus.rx_valid    = r_valid;
    assign bus.frame_err   = r_frame_err;
    assign bus.overrun_err = r_overrun_err;
    assign bus.busy        = r_busy;
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1 by default. Consumes the oversampling enable produced by the team's divider chain and deserialises the asynchronous `rx_in` line into parallel bytes.
- Bytes are delivered through a one-entry valid/ready output register.
- Sits between the board RX pin and the game-control logic.
- Runs entirely in the `clk_in` domain. `tick_16x` is a one-cycle enable, not a clock.

Parameters:
- DATA_BITS, 8, payload bits per frame, transmitted LSB first.
- OVERSAMPLE, 16, `tick_16x` pulses per bit period. Must be even and ≥ 4.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous active-high reset.
- tick_16x  input  1  oversample enable, one `clk_in` cycle wide, OVERSAMPLE per bit period.
- rx_in  input  1  asynchronous serial line, idle high.
- rx_data  output  DATA_BITS  received byte; stable while `rx_valid` is high.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts; transfer occurs when `rx_valid && rx_ready`.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun_err  output  1  one-cycle pulse: frame completed while the holding register was still full.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, `rst` = 1):
  - Synchroniser flops = 1, state = IDLE, counters = 0.
  - `rx_data` = 0; `rx_valid`, `frame_err`, `overrun_err`, `busy` = 0.
  - Reset mid-frame discards the partial frame; no error pulse is produced.
- Input sync: `rx_in` passes through a 2-FF synchroniser (`rx_s`). All decisions use `rx_s`.
- Tick gating: the sample counter (width `$clog2(OVERSAMPLE)`) advances only on cycles where `tick_16x` = 1. In every other state, cycles without a tick hold state.
- IDLE:
  - When `rx_s` = 0 (evaluated every `clk_in` cycle), go to START with the counter cleared.
- START:
  - On tick with counter = OVERSAMPLE/2 − 1 (mid start bit):
    - if `rx_s` = 0: go to DATA, clear the counter and the bit index;
    - else (glitch/false start): return to IDLE.
- DATA:
  - On tick with counter = OVERSAMPLE − 1: shift `rx_s` into the MSB of the shift register (LSB-first line order), clear the counter, increment the bit index.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - On tick with counter = OVERSAMPLE − 1, sample `rx_s`:
    - `rx_s` = 1 → deliver (see below), then go to IDLE.
    - `rx_s` = 0 → pulse `frame_err` the next cycle, do not deliver, go to BREAK.
- BREAK:
  - Wait until `rx_s` = 1, then go to IDLE. This prevents a held-low line being decoded as repeated 0x00 frames.
- Deliver (registered, one `clk_in` cycle after the stop-sample tick):
  - If `rx_valid` = 0, or `rx_valid && rx_ready` in that same cycle: load `rx_data`, set `rx_valid`.
  - Else: keep the old `rx_data`, drop the new byte, pulse `overrun_err` for one cycle.
- Handshake:
  - `rx_valid` clears on the cycle after `rx_valid && rx_ready`, unless a deliver occurs in that same cycle, in which case it stays high with the new data.
  - `rx_ready` while `rx_valid` = 0 has no effect.
- Latency: the stop-bit centre sample occurs 0.5 + 1 + DATA_BITS bit periods after the detected falling edge. `rx_valid` rises 1 cycle after that tick. Synchroniser delay adds 2 cycles to edge detection.
- `frame_err` and `overrun_err` are mutually exclusive per frame and never stretched.

Decomposition:
- Shared package `uart_pkg`:
  - state enum: IDLE, START, DATA, STOP, BREAK;
  - default constants UART_DATA_BITS = 8 and UART_OVERSAMPLE = 16, also used by the future uart_tx.
- One natural sub-module, `sync_2ff` (1-bit, reset value parameterised to 1), reusable for other pad inputs.
- The FSM, counters and output register stay in `uart_rx`.

Test Plan:
- Frame 0xA5, stop = 1, `tick_16x` every 4th cycle, `rx_ready` = 0 → `rx_data` = 0xA5, `rx_valid` = 1 and held; `frame_err` = `overrun_err` = 0; after `rx_ready` pulse, `rx_valid` = 0 next cycle.
- `rx_in` low for 4 ticks then high (glitch) → returns to IDLE, `busy` falls, no `rx_valid`, no error.
- Frame 0x3C with stop bit = 0, line held low 3 more bit times → one `frame_err` pulse, `rx_valid` stays 0, FSM stays in BREAK until line high; following 0x5A frame received correctly.
- Frames 0x11 then 0x22 back-to-back, `rx_ready` = 0 → `rx_data` = 0x11, one `overrun_err` pulse at the second deliver; then `rx_ready` = 1 → `rx_valid` drops, data = 0x11.
- Frames 0x11 then 0x22 with `rx_ready` = 1 exactly on the second deliver cycle → `rx_data` = 0x22, `rx_valid` stays 1, no `overrun_err`.
- `rst` = 1 during DATA bit 4 of 0xFF → next cycle all outputs 0 and state IDLE; subsequent 0x81 frame received correctly.
